// File: rtl/top_bar_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_bar_pkg
// Description : Shared types, constants and BCD helpers for the top-bar game
//               controller: FSM state encoding, two-digit BCD type, bonus
//               seconds and the saturating BCD increment/add functions.
// Revision    : 1.0 - initial release
// ============================================================================
package top_bar_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    RESPAWN   = 3'd3,
    LEVEL_UP  = 3'd4,
    GAME_OVER = 3'd5,
    WIN       = 3'd6
  } state_t;

  // Two BCD digits: [1] = tens, [0] = units.
  typedef logic [1:0][3:0] bcd2_t;

  localparam logic [3:0] BONUS_SECONDS = 4'd5;

  // BCD increment that sticks at 99.
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    bcd2_t r;
    r = v;
    if (v == 8'h99) begin
      r = v;
    end else if (v[0] == 4'd9) begin
      r[0] = 4'd0;
      r[1] = v[1] + 4'd1;
    end else begin
      r[0] = v[0] + 4'd1;
    end
    return r;
  endfunction

  // BCD add of a single digit (0..9), clamped to 99.
  function automatic bcd2_t bcd_add_sat(input bcd2_t a, input logic [3:0] b);
    logic [4:0] lo;
    logic [4:0] hi;
    bcd2_t      r;
    lo = {1'b0, a[0]} + {1'b0, b};
    hi = {1'b0, a[1]};
    if (lo > 5'd9) begin
      lo = lo - 5'd10;
      hi = hi + 5'd1;
    end
    if (hi > 5'd9) begin
      r = 8'h99;
    end else begin
      r[1] = hi[3:0];
      r[0] = lo[3:0];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/top_bar_if.sv
`default_nettype none
// ============================================================================
// Module      : top_bar_if
// Description : Bus between the game controller and the BCD level timer.
//   out_of_time : timer terminal count (timer -> controller)
//   timer       : current BCD timer value (timer -> controller)
//   timer_load  : one-cycle load strobe (controller -> timer)
//   time_to_add : BCD value to load (controller -> timer)
// Modports    : master = controller side, slave = timer side
// Revision    : 1.0 - initial release
// ============================================================================
interface top_bar_if;
  import top_bar_pkg::*;

  logic  out_of_time;
  bcd2_t timer;
  logic  timer_load;
  bcd2_t time_to_add;

  modport master (
    input  out_of_time,
    input  timer,
    output timer_load,
    output time_to_add
  );

  modport slave (
    output out_of_time,
    output timer,
    input  timer_load,
    input  time_to_add
  );
endinterface
`default_nettype wire

// File: rtl/top_bar_frame_pause_counter.sv
`default_nettype none
// ============================================================================
// Module      : frame_pause_counter
// Description : Counts startOfFrame pulses while clear is low; done fires
//               combinationally together with the PAUSE_FRAMES-th pulse so
//               the controller leaves the pause on that same edge.
//   clk, reset   : clock, synchronous active-high reset
//   clear        : hold counter at zero (high outside the pause states)
//   startOfFrame : one-cycle frame pulse
//   done         : final pulse of the pause seen this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module frame_pause_counter #(
  parameter int PAUSE_FRAMES = 60
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic startOfFrame,
  output logic done
);

  localparam int CNT_W = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PAUSE_FRAMES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);
  assign done    = ~clear & startOfFrame & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (startOfFrame) begin
      cnt_d = at_last ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/top_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : top_bar_ctrl
// Description : Game-flow controller for the top status bar: hearts, BCD
//               level number, timer reload and game state.
//   clk, reset        : clock, synchronous active-high reset
//   startOfFrame      : frame pulse, paces respawn/level-up pauses
//   start_game        : starts a game from IDLE, GAME_OVER or WIN
//   hit, level_complete, bonus_req : game event pulses (honoured in PLAY)
//   tbus              : timer bus (out_of_time, timer in; timer_load,
//                       time_to_add out)
//   num_of_hearts, level_num, playing, game_over, game_won : registered status
// Config      : define TOP_BAR_BONUS_TIME_EN to enable bonus-time loads
// Revision    : 1.0 - initial release
// ============================================================================
module top_bar_ctrl
  import top_bar_pkg::*;
#(
  parameter int    START_HEARTS = 3,
  parameter bcd2_t LEVEL_TIME   = 8'h30,
  parameter bcd2_t MAX_LEVEL    = 8'h09,
  parameter int    PAUSE_FRAMES = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startOfFrame,
  input  logic             start_game,
  input  logic             hit,
  input  logic             level_complete,
  input  logic             bonus_req,
  top_bar_if.master        tbus,
  output logic [1:0]       num_of_hearts,
  output bcd2_t            level_num,
  output logic             playing,
  output logic             game_over,
  output logic             game_won
);

  localparam logic [1:0] HEARTS_INIT = 2'(START_HEARTS);
  localparam bcd2_t      LEVEL_INIT  = 8'h01;

  state_t     state_q, state_d;
  logic [1:0] hearts_q, hearts_d;
  bcd2_t      level_q, level_d;
  bcd2_t      time_to_add_q, time_to_add_d;
  logic       timer_load_q;
  logic       playing_q, game_over_q, game_won_q;
  logic       bonus_load;
  logic       heart_loss;
  logic       pause_clear;
  logic       pause_done;

  // Counter is held clear everywhere except the two pause states, so it
  // always starts from zero on entry.
  assign pause_clear = (state_q != RESPAWN) && (state_q != LEVEL_UP);

  frame_pause_counter #(
    .PAUSE_FRAMES (PAUSE_FRAMES)
  ) u_pause (
    .clk          (clk),
    .reset        (reset),
    .clear        (pause_clear),
    .startOfFrame (startOfFrame),
    .done         (pause_done)
  );

  // A simultaneous hit and timeout costs a single heart.
  assign heart_loss = hit | tbus.out_of_time;

`ifndef TOP_BAR_BONUS_TIME_EN
  logic unused_bonus;
  assign unused_bonus = ^{bonus_req, tbus.timer};
`endif

  always_comb begin
    state_d       = state_q;
    hearts_d      = hearts_q;
    level_d       = level_q;
    time_to_add_d = time_to_add_q;
    bonus_load    = 1'b0;
    case (state_q)
      IDLE, GAME_OVER, WIN: begin
        if (start_game) begin
          state_d  = LOAD;
          hearts_d = HEARTS_INIT;
          level_d  = LEVEL_INIT;
        end
      end
      LOAD: state_d = PLAY;
      PLAY: begin
        // level_complete wins over a same-cycle heart loss.
        if (level_complete) begin
          if (level_q == MAX_LEVEL) begin
            state_d = WIN;
          end else begin
            level_d = bcd_inc(level_q);
            state_d = LEVEL_UP;
          end
        end else if (heart_loss) begin
          hearts_d = hearts_q - 2'd1;
          state_d  = (hearts_d == 2'd0) ? GAME_OVER : RESPAWN;
        end
`ifdef TOP_BAR_BONUS_TIME_EN
        else if (bonus_req) begin
          time_to_add_d = bcd_add_sat(tbus.timer, BONUS_SECONDS);
          bonus_load    = 1'b1;
        end
`endif
      end
      RESPAWN, LEVEL_UP: begin
        if (pause_done) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD) time_to_add_d = LEVEL_TIME;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hearts_q      <= HEARTS_INIT;
      level_q       <= LEVEL_INIT;
      time_to_add_q <= LEVEL_TIME;
      timer_load_q  <= 1'b0;
      playing_q     <= 1'b0;
      game_over_q   <= 1'b0;
      game_won_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hearts_q      <= hearts_d;
      level_q       <= level_d;
      time_to_add_q <= time_to_add_d;
      timer_load_q  <= (state_d == LOAD) | bonus_load;
      playing_q     <= (state_d == PLAY);
      game_over_q   <= (state_d == GAME_OVER);
      game_won_q    <= (state_d == WIN);
    end
  end

  assign tbus.timer_load  = timer_load_q;
  assign tbus.time_to_add = time_to_add_q;
  assign num_of_hearts    = hearts_q;
  assign level_num        = level_q;
  assign playing          = playing_q;
  assign game_over        = game_over_q;
  assign game_won         = game_won_q;

endmodule
`default_nettype wire

// File: tb/tb_top_bar_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_top_bar_ctrl
// Description : Directed self-checking bench for top_bar_ctrl (MAX_LEVEL=12).
//               Bonus-time vectors run when TOP_BAR_BONUS_TIME_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top_bar_ctrl;
  import top_bar_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       sof, start_game, hit, level_complete, bonus_req;
  logic [1:0] num_of_hearts;
  bcd2_t      level_num;
  logic       playing, game_over, game_won;

  int n_checks = 0;
  int n_errors = 0;

  top_bar_if tbus ();

  top_bar_ctrl #(
    .START_HEARTS (3),
    .LEVEL_TIME   (8'h30),
    .MAX_LEVEL    (8'h12),
    .PAUSE_FRAMES (60)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (sof),
    .start_game     (start_game),
    .hit            (hit),
    .level_complete (level_complete),
    .bonus_req      (bonus_req),
    .tbus           (tbus),
    .num_of_hearts  (num_of_hearts),
    .level_num      (level_num),
    .playing        (playing),
    .game_over      (game_over),
    .game_won       (game_won)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      sof = 1'b1; tick();
      sof = 1'b0; tick();
    end
  endtask

  // level_complete in PLAY, then the full level-up pause back into PLAY.
  task automatic advance_level;
    level_complete = 1'b1; tick();
    level_complete = 1'b0;
    frames(60);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; sof = 1'b0; start_game = 1'b0; hit = 1'b0;
    level_complete = 1'b0; bonus_req = 1'b0;
    tbus.out_of_time = 1'b0; tbus.timer = 8'h00;
    tick(); tick();
    check_eq("rst_hearts",  num_of_hearts, 2'd3);
    check_eq("rst_level",   level_num, 8'h01);
    check_eq("rst_tta",     tbus.time_to_add, 8'h30);
    check_eq("rst_flags",   {tbus.timer_load, playing, game_over, game_won}, 4'b0000);
    reset = 1'b0; tick();

    // start -> LOAD for one cycle -> PLAY
    start_game = 1'b1; tick(); start_game = 1'b0;
    check_eq("load_tl",     tbus.timer_load, 1'b1);
    check_eq("load_tta",    tbus.time_to_add, 8'h30);
    check_eq("load_play",   playing, 1'b0);
    tick();
    check_eq("play_on",     playing, 1'b1);
    check_eq("play_tl",     tbus.timer_load, 1'b0);
    check_eq("play_hearts", num_of_hearts, 2'd3);
    check_eq("play_level",  level_num, 8'h01);

    // hit and timeout together: one heart
    hit = 1'b1; tbus.out_of_time = 1'b1; tick();
    hit = 1'b0; tbus.out_of_time = 1'b0;
    check_eq("dbl_hearts",  num_of_hearts, 2'd2);
    check_eq("dbl_play",    playing, 1'b0);
    start_game = 1'b1; hit = 1'b1; tick(); start_game = 1'b0; hit = 1'b0;
    check_eq("resp_ign",    {num_of_hearts, tbus.timer_load}, {2'd2, 1'b0});
    frames(59);
    check_eq("resp59_tl",   {tbus.timer_load, playing}, 2'b00);
    sof = 1'b1; tick(); sof = 1'b0;
    check_eq("resp60_tl",   tbus.timer_load, 1'b1);
    check_eq("resp60_tta",  tbus.time_to_add, 8'h30);
    tick();
    check_eq("resp_play",   {playing, tbus.timer_load}, 2'b10);

    // reset in the middle of a respawn pause
    hit = 1'b1; tick(); hit = 1'b0;
    check_eq("hit2_hearts", num_of_hearts, 2'd1);
    frames(10);
    reset = 1'b1; tick();
    check_eq("mid_rst_hearts", num_of_hearts, 2'd3);
    check_eq("mid_rst_flags",  {tbus.timer_load, playing, game_over}, 3'b000);
    reset = 1'b0; tick();
    check_eq("idle_stays",  {tbus.timer_load, playing}, 2'b00);

    // level progression up to MAX_LEVEL
    start_game = 1'b1; tick(); start_game = 1'b0; tick();
    for (int i = 0; i < 8; i++) advance_level();
    check_eq("lvl09",       level_num, 8'h09);
    check_eq("lvl09_play",  playing, 1'b1);
    level_complete = 1'b1; tick(); level_complete = 1'b0;
    check_eq("lvl10",       level_num, 8'h10);
    check_eq("lvl10_flags", {playing, game_won, tbus.timer_load}, 3'b000);
    frames(60);
    check_eq("lvl10_play",  playing, 1'b1);
    advance_level();
    advance_level();
    check_eq("lvl12",       level_num, 8'h12);
    level_complete = 1'b1; hit = 1'b1; tick(); level_complete = 1'b0; hit = 1'b0;
    check_eq("win_flag",    {game_won, playing}, 2'b10);
    check_eq("win_hearts",  num_of_hearts, 2'd3);
    check_eq("win_level",   level_num, 8'h12);

    // restart from WIN
    start_game = 1'b1; tick(); start_game = 1'b0;
    check_eq("restart_load", {tbus.timer_load, game_won, level_num}, {1'b1, 1'b0, 8'h01});
    tick();

`ifdef TOP_BAR_BONUS_TIME_EN
    tbus.timer = 8'h97; bonus_req = 1'b1; tick(); bonus_req = 1'b0;
    check_eq("bonus97_tl",  tbus.timer_load, 1'b1);
    check_eq("bonus97_tta", tbus.time_to_add, 8'h99);
    check_eq("bonus97_pl",  playing, 1'b1);
    tick();
    check_eq("bonus97_end", tbus.timer_load, 1'b0);
    tbus.timer = 8'h27; bonus_req = 1'b1; tick(); bonus_req = 1'b0;
    check_eq("bonus27_tl",  tbus.timer_load, 1'b1);
    check_eq("bonus27_tta", tbus.time_to_add, 8'h32);
    tick();
    check_eq("bonus27_end", tbus.timer_load, 1'b0);
`else
    tbus.timer = 8'h97; bonus_req = 1'b1; tick(); bonus_req = 1'b0;
    check_eq("nobonus_tl",  tbus.timer_load, 1'b0);
    check_eq("nobonus_tta", tbus.time_to_add, 8'h30);
    tick();
`endif

    // three losses -> game over
    hit = 1'b1; tick(); hit = 1'b0;
    frames(60);
    hit = 1'b1; tick(); hit = 1'b0;
    frames(60);
    check_eq("go_pre",      {num_of_hearts, playing}, {2'd1, 1'b1});
    tbus.out_of_time = 1'b1; tick(); tbus.out_of_time = 1'b0;
    check_eq("go_flag",     {game_over, playing}, 2'b10);
    check_eq("go_hearts",   num_of_hearts, 2'd0);
    hit = 1'b1; level_complete = 1'b1; tick(); hit = 1'b0; level_complete = 1'b0;
    check_eq("go_ignore",   {game_over, num_of_hearts, level_num}, {1'b1, 2'd0, 8'h01});
    start_game = 1'b1; tick(); start_game = 1'b0;
    check_eq("go_restart",  {game_over, tbus.timer_load, num_of_hearts}, {1'b0, 1'b1, 2'd3});

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/top_bar_ctrl.md
TOP_BAR_CTRL -- requirements
Module: top_bar_ctrl

Interface
REQ-001 SHALL have parameter START_HEARTS, default 3: hearts at game start, range 1..3.
REQ-002 SHALL have parameter LEVEL_TIME, default 8'h30: BCD seconds loaded at every level or respawn start.
REQ-003 SHALL have parameter MAX_LEVEL, default 8'h09: BCD final level number.
REQ-004 SHALL have parameter PAUSE_FRAMES, default 60: frames spent in the respawn and level-up pauses.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous, active-high).
REQ-006 SHALL have ports startOfFrame (in, 1, one-cycle frame pulse) and start_game (in, 1, pulse).
REQ-007 SHALL have ports hit (in, 1, player-damage pulse), level_complete (in, 1, pulse) and bonus_req (in, 1, pulse).
REQ-008 SHALL have ports out_of_time (in, 1, timer terminal count) and timer (in, [1:0][3:0], current BCD timer value).
REQ-009 SHALL have outputs timer_load (1, pulse) and time_to_add ([1:0][3:0], BCD load value).
REQ-010 SHALL have outputs num_of_hearts ([1:0]) and level_num ([1:0][3:0], BCD).
REQ-011 SHALL have outputs playing, game_over and game_won (1 bit each, level signals).

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, PLAY, RESPAWN, LEVEL_UP, GAME_OVER and WIN.
REQ-013 SHALL leave IDLE, GAME_OVER or WIN on start_game, setting hearts=START_HEARTS and level=01 and entering LOAD.
REQ-014 SHALL spend exactly one cycle in LOAD with timer_load=1 and time_to_add=LEVEL_TIME, then enter PLAY.
REQ-015 SHALL pulse timer_load only in LOAD or on a bonus, and otherwise hold it at 0.
REQ-016 SHALL assert playing only in PLAY.
REQ-017 SHALL treat hit or out_of_time in PLAY as exactly one heart loss, including when both occur in the same cycle.
REQ-018 SHALL, on a heart loss, decrement hearts, entering GAME_OVER if the result is 0 and RESPAWN otherwise.
REQ-019 SHALL, on level_complete in PLAY, enter WIN if level==MAX_LEVEL, and otherwise BCD-increment level (09->10, 99 saturates) and enter LEVEL_UP.
REQ-020 SHALL give level_complete priority over a heart loss in the same cycle, so that hearts are unchanged.
REQ-021 SHALL count PAUSE_FRAMES startOfFrame pulses in RESPAWN or LEVEL_UP, with the counter cleared on entry, then enter LOAD.
REQ-022 SHALL ignore all game events outside PLAY and ignore start_game inside PLAY, LOAD, RESPAWN and LEVEL_UP.
REQ-023 SHALL hold game_over=1 exactly while in GAME_OVER and game_won=1 exactly while in WIN.
REQ-024 SHALL update the FSM on the cycle after the event, with all outputs registered, giving a one-cycle event-to-output latency.

Reset
REQ-025 SHALL, while reset=1, force state=IDLE, num_of_hearts=START_HEARTS, level_num=8'h01, time_to_add=LEVEL_TIME, all 1-bit outputs=0 and the frame counter=0.
REQ-026 SHALL let reset take precedence over every input, including a reset asserted mid-pause or mid-LOAD.

Configuration
REQ-027 SHALL compile bonus-time support in only when TOP_BAR_BONUS_TIME_EN is defined.
REQ-028 SHALL, with the macro defined, on bonus_req in PLAY with no heart loss or level_complete that cycle, drive time_to_add=min(timer+5, 99) in BCD and pulse timer_load for one cycle, staying in PLAY.
REQ-029 SHALL, without the macro, ignore bonus_req and produce no timer_load outside LOAD.

Structure
REQ-030 SHALL take the state enum, the BCD digit-pair typedef, the BONUS_SECONDS=5 constant and the bcd_inc/bcd_add_sat helper functions from the shared package top_bar_pkg.
REQ-031 SHALL place the frame counting in one sub-module, frame_pause_counter (inputs: clear, startOfFrame; output: done).

Verification
REQ-032 SHALL cover: reset, then start_game -> LOAD for 1 cycle, timer_load=1, time_to_add=8'h30, then playing=1, hearts=3, level=8'h01.
REQ-033 SHALL cover: hit and out_of_time in the same PLAY cycle -> hearts 3->2, RESPAWN, then after 60 startOfFrame pulses, a timer_load with 8'h30.
REQ-034 SHALL cover: three heart losses from START_HEARTS=3 -> game_over=1, with hit and level_complete ignored afterwards.
REQ-035 SHALL cover: level_complete at level 09 with MAX_LEVEL=8'h12 -> level_num=8'h10, LEVEL_UP, and level_complete with hit at level 8'h12 -> game_won=1 and hearts unchanged.
REQ-036 SHALL cover, with the macro: timer=8'h97 and bonus_req -> time_to_add=8'h99; timer=8'h27 -> 8'h32; each with a one-cycle timer_load.
REQ-037 SHALL cover: reset asserted during RESPAWN -> IDLE next cycle, hearts=3, no timer_load.
